// File: rtl/req_capture_4_pkg.sv
// Shared constants and types for the request capture stage feeding the
// 4-to-2 priority encoder.
package req_capture_4_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/req_capture_4_if.sv
// Valid/ready handshake carrying the encoded ID of the offered request.
interface req_capture_4_if;
  import req_capture_4_pkg::*;

  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic           irq_ready;

  modport master (
    output irq_valid,
    output irq_id,
    input  irq_ready
  );

  modport slave (
    input  irq_valid,
    input  irq_id,
    output irq_ready
  );

endinterface

// File: rtl/req_capture_4_sync.sv
// Single-bit synchroniser chain followed by an event detector
// (rising edge or level, chosen by EDGE_MODE).
module req_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic ev
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   s;
  logic                   s_d;

  assign s = sr[SYNC_STAGES-1];

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[SYNC_STAGES-2:0], d};
  end

  // One-cycle history of the synchronised bit for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign ev = (EDGE_MODE != 0) ? (s & ~s_d) : s;

endmodule

// File: rtl/req_capture_4.sv
// Request capture stage: synchronises four request lines, latches events
// into a pending register and offers the highest-priority unmasked one
// (index 3 highest) as a registered ID on a valid/ready handshake.
module req_capture_4
  import req_capture_4_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_in,
  input  logic [NREQ-1:0]   mask,
  output logic [NREQ-1:0]   pend,
  req_capture_4_if.master   irq
);

  logic [NREQ-1:0] ev;
  logic [NREQ-1:0] pend_q;
  logic [NREQ-1:0] pend_next;
  logic [NREQ-1:0] clr_vec;
  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  id_next;
  state_t          state;
  state_t          state_next;

  // Highest set index wins.
  function automatic logic [IDW-1:0] prio_sel(input logic [NREQ-1:0] v);
    prio_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (v[i]) prio_sel = IDW'(i);
    end
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_sync
    req_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (req_in[g]),
      .ev   (ev[g])
    );
  end

  assign elig = pend_q & mask;

  // Next-state, ID load and accept-clear decode.
  always_comb begin
    state_next = state;
    id_next    = id_q;
    clr_vec    = '0;
    case (state)
      IDLE: begin
        if (elig != '0) begin
          id_next    = prio_sel(elig);
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (irq.irq_ready) begin
          clr_vec[id_q] = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Events are OR'd in after the clear so a coincident set always wins.
  assign pend_next = (pend_q & ~clr_vec) | ev;

  // Pending register, FSM state and offered ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      state  <= IDLE;
      id_q   <= '0;
    end else begin
      pend_q <= pend_next;
      state  <= state_next;
      id_q   <= id_next;
    end
  end

  assign pend          = pend_q;
  assign irq.irq_valid = (state == OFFER);
  assign irq.irq_id    = id_q;

endmodule
